// File: rtl/sprite_mem_arbiter_if.sv
// Requester/sprite-table bundle for the sprite memory arbiter.
// The master side is the requesters plus the table; the slave side is the arbiter.
interface sprite_mem_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        we;
    logic [NREQ-1:0]        lock;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ*DATA_W-1:0] wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rvalid;
    logic [DATA_W-1:0]      rdata;
    logic                   mem_re;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;
    logic                   busy;
    logic                   lock_timeout;

    modport master (
        output req, we, lock, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_re, mem_we, mem_addr, mem_wdata, busy, lock_timeout
    );

    modport slave (
        input  req, we, lock, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_re, mem_we, mem_addr, mem_wdata, busy, lock_timeout
    );
endinterface

// File: rtl/sprite_mem_arbiter.sv
// Round-robin arbiter for the single-port sprite table, with per-owner lock
// holding and a lock watchdog that forcibly releases an idle owner.
module sprite_mem_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    sprite_mem_arbiter_if.slave  bus
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, LOCK_HOLD} state_t;

    state_t              state_reg, state_next;
    logic [OW-1:0]       owner_reg, owner_next;
    logic [OW-1:0]       last_owner_reg, last_owner_next;
    logic                we_reg, we_next;
    logic                lock_reg, lock_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic [NREQ-1:0]     rvalid_reg, rvalid_next;
    logic [3:0]          idle_cnt_reg, idle_cnt_next;
    logic                timeout;

    logic [ADDR_W-1:0]   addr_arr  [NREQ];
    logic [DATA_W-1:0]   wdata_arr [NREQ];
    logic [NREQ-1:0]     owner_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]     = bus.addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi]    = bus.wdata[gi*DATA_W +: DATA_W];
            assign owner_onehot[gi] = (owner_reg == OW'(gi));
        end
    endgenerate

    // Round-robin search starting one past the last owner, wrapping at NREQ.
    logic          rr_found;
    logic [OW-1:0] rr_winner;
    logic [OW:0]   rr_sum;
    logic [OW-1:0] rr_cand;

    always_comb begin
        rr_found  = 1'b0;
        rr_winner = last_owner_reg;
        rr_sum    = '0;
        rr_cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_sum = {1'b0, last_owner_reg} + (OW+1)'(k);
            if (rr_sum >= (OW+1)'(NREQ)) begin
                rr_sum = rr_sum - (OW+1)'(NREQ);
            end
            rr_cand = rr_sum[OW-1:0];
            if (!rr_found && bus.req[rr_cand]) begin
                rr_found  = 1'b1;
                rr_winner = rr_cand;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        we_next         = we_reg;
        lock_next       = lock_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        rdata_next      = rdata_reg;
        rvalid_next     = '0;
        idle_cnt_next   = idle_cnt_reg;
        timeout         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rr_found) begin
                    owner_next      = rr_winner;
                    last_owner_next = rr_winner;
                    we_next         = bus.we[rr_winner];
                    lock_next       = bus.lock[rr_winner];
                    addr_next       = addr_arr[rr_winner];
                    wdata_next      = wdata_arr[rr_winner];
                    state_next      = ISSUE;
                end
            end
            ISSUE: begin
                if (!we_reg) begin
                    state_next = RESP;
                end else if (lock_reg) begin
                    state_next    = LOCK_HOLD;
                    idle_cnt_next = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            RESP: begin
                rdata_next  = bus.mem_rdata;
                rvalid_next = owner_onehot;
                if (lock_reg) begin
                    state_next    = LOCK_HOLD;
                    idle_cnt_next = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            LOCK_HOLD: begin
                // Only the owner is looked at; last_owner is left untouched.
                if (bus.req[owner_reg]) begin
                    we_next       = bus.we[owner_reg];
                    lock_next     = bus.lock[owner_reg];
                    addr_next     = addr_arr[owner_reg];
                    wdata_next    = wdata_arr[owner_reg];
                    idle_cnt_next = '0;
                    state_next    = ISSUE;
                end else if (!bus.lock[owner_reg]) begin
                    state_next = IDLE;
                end else if (idle_cnt_reg == 4'd14) begin
                    timeout       = 1'b1;
                    idle_cnt_next = 4'd15;
                    state_next    = IDLE;
                end else begin
                    idle_cnt_next = idle_cnt_reg + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            last_owner_reg <= OW'(NREQ-1);
            we_reg         <= 1'b0;
            lock_reg       <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            rvalid_reg     <= '0;
            idle_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            we_reg         <= we_next;
            lock_reg       <= lock_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            rdata_reg      <= rdata_next;
            rvalid_reg     <= rvalid_next;
            idle_cnt_reg   <= idle_cnt_next;
        end
    end

    // Outputs are forced quiet while rst is high so nothing leaks during reset.
    logic issuing;
    assign issuing = (state_reg == ISSUE) && !rst;

    assign bus.gnt          = issuing ? owner_onehot : '0;
    assign bus.mem_re       = issuing && !we_reg;
    assign bus.mem_we       = issuing && we_reg;
    assign bus.mem_addr     = issuing ? addr_reg : '0;
    assign bus.mem_wdata    = issuing ? wdata_reg : '0;
    assign bus.busy         = (state_reg != IDLE) && !rst;
    assign bus.lock_timeout = timeout && !rst;
    assign bus.rvalid       = rst ? '0 : rvalid_reg;
    assign bus.rdata        = rst ? '0 : rdata_reg;

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Directed bench for sprite_mem_arbiter: expected grants/reads go into a
// scoreboard when stimulus is driven and are checked as the DUT produces them.
module tb_sprite_mem_arbiter;
    localparam int NREQ   = 3;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 64;

    logic clk;
    logic rst;

    sprite_mem_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sprite_mem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        bit          we;
        logic [7:0]  addr;
        logic [63:0] wdata;
    } gnt_exp_t;

    typedef struct {
        int          idx;
        logic [63:0] data;
        int          due;
    } rd_exp_t;

    gnt_exp_t    gq[$];
    rd_exp_t     rq[$];
    logic [63:0] ref_mem   [256];
    logic [63:0] table_mem [256];
    bit          loaded;
    logic [NREQ-1:0] gnt_seen;
    int          cyc;
    int          checks;
    int          errors;

    function automatic logic [63:0] init_val(int a);
        logic [7:0] av;
        av = a[7:0];
        if (av == 8'h05) return 64'hC000_0A0B_0402_0300;
        return {8'hA0, 24'h0, av, 16'h1234, ~av};
    endfunction

    // Sprite table model: data appears on mem_rdata the cycle after mem_re.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int a = 0; a < 256; a++) table_mem[a] <= init_val(a);
            bus.mem_rdata <= '0;
            loaded <= 1'b1;
        end else begin
            if (bus.mem_re) bus.mem_rdata <= table_mem[bus.mem_addr];
            if (bus.mem_we) table_mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic observe();
        gnt_exp_t g;
        rd_exp_t  r;
        gnt_seen = bus.gnt;
        if (bus.gnt != '0) begin
            if (gq.size() == 0) begin
                chk("unexpected_gnt", 64'(bus.gnt), 64'd0);
            end else begin
                g = gq.pop_front();
                $display("cyc %0d: gnt req%0d %s addr=%h", cyc, g.idx, g.we ? "write" : "read", bus.mem_addr);
                chk("gnt_owner", 64'(bus.gnt), 64'd1 << g.idx);
                chk("mem_we", 64'(bus.mem_we), 64'(g.we));
                chk("mem_re", 64'(bus.mem_re), 64'(!g.we));
                chk("mem_addr", 64'(bus.mem_addr), 64'(g.addr));
                if (g.we) begin
                    chk("mem_wdata", bus.mem_wdata, g.wdata);
                    ref_mem[g.addr] = g.wdata;
                end else begin
                    r.idx  = g.idx;
                    r.data = ref_mem[g.addr];
                    r.due  = cyc + 2;
                    rq.push_back(r);
                end
            end
            bus.req = bus.req & ~bus.gnt;
        end
        if (bus.rvalid != '0) begin
            if (rq.size() == 0) begin
                chk("unexpected_rvalid", 64'(bus.rvalid), 64'd0);
            end else begin
                r = rq.pop_front();
                $display("cyc %0d: rvalid req%0d rdata=%h", cyc, r.idx, bus.rdata);
                chk("rvalid_owner", 64'(bus.rvalid), 64'd1 << r.idx);
                chk("rdata", bus.rdata, r.data);
                chk("read_latency", 64'(cyc), 64'(r.due));
            end
        end else if (rq.size() > 0 && cyc > rq[0].due) begin
            chk("rvalid_overdue", 64'(cyc), 64'(rq[0].due));
            void'(rq.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        observe();
    endtask

    task automatic drive(int i, bit w, bit lk, logic [7:0] a, logic [63:0] d);
        bus.we[i]                 = w;
        bus.lock[i]               = lk;
        bus.addr[i*ADDR_W +: ADDR_W] = a;
        bus.wdata[i*DATA_W +: DATA_W] = d;
        bus.req[i]                = 1'b1;
    endtask

    task automatic expect_gnt(int i, bit w, logic [7:0] a, logic [63:0] d);
        gnt_exp_t g;
        g.idx = i; g.we = w; g.addr = a; g.wdata = d;
        gq.push_back(g);
    endtask

    task automatic wait_gnt(int i, int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!gnt_seen[i] && n < budget);
        if (!gnt_seen[i]) chk("gnt_wait_timeout", 64'(gnt_seen[i]), 64'd1);
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while ((gq.size() + rq.size() != 0 || bus.busy) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_pending", 64'(gq.size() + rq.size()), 64'd0);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_val(a);
        rst = 1'b1;
        bus.req = '0; bus.we = '0; bus.lock = '0; bus.addr = '0; bus.wdata = '0;

        // Reset state
        tick();
        tick();
        chk("rst_gnt", 64'(bus.gnt), 64'd0);
        chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("rst_mem_strobes", 64'({bus.mem_re, bus.mem_we}), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_lock_timeout", 64'(bus.lock_timeout), 64'd0);
        chk("rst_rdata", bus.rdata, 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 64'(bus.busy), 64'd0);

        // All three read at once: round robin from last_owner=2 gives 0,1,2
        drive(0, 1'b0, 1'b0, 8'h01, 64'd0);
        drive(1, 1'b0, 1'b0, 8'h02, 64'd0);
        drive(2, 1'b0, 1'b0, 8'h03, 64'd0);
        expect_gnt(0, 1'b0, 8'h01, 64'd0);
        expect_gnt(1, 1'b0, 8'h02, 64'd0);
        expect_gnt(2, 1'b0, 8'h03, 64'd0);
        drain(40);

        // Locked read-modify-write by 0 keeps requester 1 waiting
        drive(1, 1'b0, 1'b0, 8'h10, 64'd0);
        drive(0, 1'b0, 1'b1, 8'h05, 64'd0);
        expect_gnt(0, 1'b0, 8'h05, 64'd0);
        expect_gnt(0, 1'b1, 8'h05, 64'h8000_0A0B_0000_0300);
        expect_gnt(1, 1'b0, 8'h10, 64'd0);
        wait_gnt(0, 10);
        drive(0, 1'b1, 1'b0, 8'h05, 64'h8000_0A0B_0000_0300);
        drain(40);

        // Lock watchdog: owner 0 goes quiet with lock held, req[2] waits
        drive(0, 1'b1, 1'b1, 8'h20, 64'h0123_4567_89AB_CDEF);
        expect_gnt(0, 1'b1, 8'h20, 64'h0123_4567_89AB_CDEF);
        expect_gnt(2, 1'b0, 8'h20, 64'd0);
        wait_gnt(0, 10);
        drive(2, 1'b0, 1'b0, 8'h20, 64'd0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk($sformatf("lock_timeout_c%0d", k), 64'(bus.lock_timeout), 64'(k == 15));
            chk($sformatf("lock_busy_c%0d", k), 64'(bus.busy), 64'd1);
        end
        bus.lock[0] = 1'b0;
        tick();
        chk("after_timeout_busy", 64'(bus.busy), 64'd0);
        chk("after_timeout_pulse", 64'(bus.lock_timeout), 64'd0);
        wait_gnt(2, 5);
        drain(20);

        // Full-scale write, no response, then read it back
        drive(1, 1'b1, 1'b0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_gnt(1, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_gnt(1, 10);
        tick();
        chk("write_one_cycle", 64'(bus.mem_we), 64'd0);
        drive(2, 1'b0, 1'b0, 8'hFF, 64'd0);
        expect_gnt(2, 1'b0, 8'hFF, 64'd0);
        drain(20);

        // Reset during RESP aborts the read
        drive(1, 1'b0, 1'b0, 8'h05, 64'd0);
        expect_gnt(1, 1'b0, 8'h05, 64'd0);
        wait_gnt(1, 10);
        tick();
        chk("resp_busy", 64'(bus.busy), 64'd1);
        rq.delete();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        cyc++;
        observe();
        chk("abort_rvalid", 64'(bus.rvalid), 64'd0);
        chk("abort_rdata", bus.rdata, 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        tick();
        chk("abort_rvalid_late", 64'(bus.rvalid), 64'd0);

        // last_owner back to NREQ-1: requester 0 beats requester 2
        drive(2, 1'b0, 1'b0, 8'h07, 64'd0);
        drive(0, 1'b0, 1'b0, 8'h06, 64'd0);
        expect_gnt(0, 1'b0, 8'h06, 64'd0);
        expect_gnt(2, 1'b0, 8'h07, 64'd0);
        drain(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
